control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: top-level run/halt FSM and instruction decoder for a
// small 16-bit processor. It owns the program-loader / datapath handover,
// latches ALU flags for conditional branches, counts retired instructions and
// flags undefined opcodes.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             Pre_C,
  input  logic             Pre_V,
  input  logic             Pre_Z,
  input  logic             Pre_N,
  output logic             test_normal,
  output logic             clr,
  output logic             flag_HLT,
  output logic             ADC,
  output logic             SUB,
  output logic             SBB,
  output logic             Src_ALU_B,
  output logic             Src_Read_B,
  output logic             flag_mem_RF,
  output logic             flag_ALU_RF,
  output logic             flag_Rm_RF,
  output logic             LHI,
  output logic             LLI,
  output logic             RF_write_en,
  output logic             data_write_en,
  output logic             flag_OutR,
  output logic             JMP,
  output logic             BRANCH,
  output logic             flag_label_PC,
  output logic             flag_Rm_PC,
  output logic             flag_Rd_PC,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LLI  = 5'b00001;
  localparam logic [4:0] OP_LHI  = 5'b00010;
  localparam logic [4:0] OP_LDR  = 5'b00011;
  localparam logic [4:0] OP_STR  = 5'b00101;
  localparam logic [4:0] OP_MOV  = 5'b00110;
  localparam logic [4:0] OP_BCND = 5'b11000;
  localparam logic [4:0] OP_JR   = 5'b11001;
  localparam logic [4:0] OP_JD   = 5'b11010;
  localparam logic [4:0] OP_OUT  = 5'b11100;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  state_e           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic [4:0]       opcode;
  logic             in_run;
  logic             alu_op;
  logic             illegal_op;
  logic             branch_taken;
  logic             unused_instr_bits;

  assign opcode            = instr[15:11];
  assign in_run            = (state_q == S_RUN);
  assign unused_instr_bits = ^instr[7:2];

  // Status outputs are pure decodes of the state register, so an async reset
  // forces them to their loader-owned values without waiting for a clock.
  assign test_normal = (state_q == S_IDLE) || (state_q == S_HALT);
  assign clr         = (state_q == S_CLEAR);
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

  // Next-state logic: start is only honoured from IDLE or HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_HALT:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (opcode == OP_HLT) state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Branch condition, evaluated on the latched flags rather than Pre_*.
  always_comb begin
    unique case (instr[10:8])
      3'b000:  branch_taken = flags_q.z;
      3'b001:  branch_taken = !flags_q.z;
      3'b010:  branch_taken = flags_q.c;
      3'b011:  branch_taken = !flags_q.c;
      3'b100:  branch_taken = flags_q.n;
      3'b101:  branch_taken = !flags_q.n;
      3'b110:  branch_taken = flags_q.v;
      default: branch_taken = 1'b1;
    endcase
  end

  // Instruction decode: every datapath control is low unless RUN selects it.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so
    // that no path leaves a signal unassigned and infers a latch.
    flag_HLT      = 1'b0;
    ADC           = 1'b0;
    SUB           = 1'b0;
    SBB           = 1'b0;
    Src_ALU_B     = 1'b0;
    Src_Read_B    = 1'b0;
    flag_mem_RF   = 1'b0;
    flag_ALU_RF   = 1'b0;
    flag_Rm_RF    = 1'b0;
    LHI           = 1'b0;
    LLI           = 1'b0;
    RF_write_en   = 1'b0;
    data_write_en = 1'b0;
    flag_OutR     = 1'b0;
    JMP           = 1'b0;
    BRANCH        = 1'b0;
    flag_label_PC = 1'b0;
    flag_Rm_PC    = 1'b0;
    flag_Rd_PC    = 1'b0;
    alu_op        = 1'b0;
    illegal_op    = 1'b0;
    if (in_run) begin
      flag_HLT = 1'b1;
      unique case (opcode)
        OP_ALU: begin
          alu_op      = 1'b1;
          flag_ALU_RF = 1'b1;
          RF_write_en = 1'b1;
          ADC         = (instr[1:0] == 2'b01);
          SUB         = (instr[1:0] == 2'b10);
          SBB         = (instr[1:0] == 2'b11);
        end
        OP_LLI: begin
          LLI         = 1'b1;
          RF_write_en = 1'b1;
        end
        OP_LHI: begin
          LHI         = 1'b1;
          Src_Read_B  = 1'b1;
          RF_write_en = 1'b1;
        end
        OP_LDR: begin
          Src_ALU_B   = 1'b1;
          flag_mem_RF = 1'b1;
          RF_write_en = 1'b1;
        end
        OP_STR: begin
          Src_ALU_B     = 1'b1;
          Src_Read_B    = 1'b1;
          data_write_en = 1'b1;
        end
        OP_MOV: begin
          flag_Rm_RF  = 1'b1;
          RF_write_en = 1'b1;
        end
        OP_BCND: begin
          BRANCH        = branch_taken;
          flag_label_PC = branch_taken;
        end
        OP_JR: begin
          JMP        = 1'b1;
          flag_Rm_PC = 1'b1;
        end
        OP_JD: begin
          JMP        = 1'b1;
          flag_Rd_PC = 1'b1;
        end
        OP_OUT:  flag_OutR = 1'b1;
        OP_HLT:  flag_HLT  = 1'b0;
        default: illegal_op = 1'b1;
      endcase
    end
  end

  // Next values for flags, retired count and sticky illegal; all hold in
  // IDLE and HALT so the loader can read them back.
  always_comb begin
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    if (state_q == S_CLEAR) begin
      flags_d   = '0;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end else if (in_run) begin
      if (alu_op) flags_d = '{c: Pre_C, v: Pre_V, z: Pre_Z, n: Pre_N};
      if (illegal_op) illegal_d = 1'b1;
      if ((opcode != OP_HLT) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and datapath-status registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clr_n) begin
      state_q   <= S_IDLE;
      flags_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a directed vector table in RUN,
// hand-written sequences for halt/restart, illegal opcodes and async reset,
// then randomized stimulus against a behavioural model of the sequencer.
module tb_control_sequencer;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Control word bit masks, one per datapath control output.
  localparam logic [17:0] M_ADC   = 18'b1 << 17;
  localparam logic [17:0] M_SUB   = 18'b1 << 16;
  localparam logic [17:0] M_SBB   = 18'b1 << 15;
  localparam logic [17:0] M_ALUB  = 18'b1 << 14;
  localparam logic [17:0] M_RDB   = 18'b1 << 13;
  localparam logic [17:0] M_MEMRF = 18'b1 << 12;
  localparam logic [17:0] M_ALURF = 18'b1 << 11;
  localparam logic [17:0] M_RMRF  = 18'b1 << 10;
  localparam logic [17:0] M_LHI   = 18'b1 << 9;
  localparam logic [17:0] M_LLI   = 18'b1 << 8;
  localparam logic [17:0] M_RFW   = 18'b1 << 7;
  localparam logic [17:0] M_DWE   = 18'b1 << 6;
  localparam logic [17:0] M_OUT   = 18'b1 << 5;
  localparam logic [17:0] M_JMP   = 18'b1 << 4;
  localparam logic [17:0] M_BR    = 18'b1 << 3;
  localparam logic [17:0] M_LBL   = 18'b1 << 2;
  localparam logic [17:0] M_RMPC  = 18'b1 << 1;
  localparam logic [17:0] M_RDPC  = 18'b1 << 0;

  logic clk, clr_n, start;
  logic [15:0] instr;
  logic Pre_C, Pre_V, Pre_Z, Pre_N;
  logic test_normal, clr, flag_HLT;
  logic ADC, SUB, SBB, Src_ALU_B, Src_Read_B;
  logic flag_mem_RF, flag_ALU_RF, flag_Rm_RF, LHI, LLI, RF_write_en;
  logic data_write_en, flag_OutR, JMP, BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC;
  logic halted, illegal;
  logic [CNT_W-1:0] instr_count;
  logic [17:0] ctrl;

  int checks;
  int failures;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .instr(instr),
    .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
    .test_normal(test_normal), .clr(clr), .flag_HLT(flag_HLT),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B),
    .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
    .LHI(LHI), .LLI(LLI), .RF_write_en(RF_write_en),
    .data_write_en(data_write_en), .flag_OutR(flag_OutR), .JMP(JMP), .BRANCH(BRANCH),
    .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  assign ctrl = {ADC, SUB, SBB, Src_ALU_B, Src_Read_B, flag_mem_RF, flag_ALU_RF,
                 flag_Rm_RF, LHI, LLI, RF_write_en, data_write_en, flag_OutR, JMP,
                 BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  cvzn;
    logic        st;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[25];

  logic [4:0] valid_ops[11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6,
                                5'd24, 5'd25, 5'd26, 5'd28, 5'd31};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic tn, input logic cl,
                              input logic hlt, input logic hd, input logic [17:0] c,
                              input logic ill, input logic [CNT_W-1:0] cnt);
    check({tag, ".test_normal"}, 32'(test_normal), 32'(tn));
    check({tag, ".clr"},         32'(clr),         32'(cl));
    check({tag, ".flag_HLT"},    32'(flag_HLT),    32'(hlt));
    check({tag, ".halted"},      32'(halted),      32'(hd));
    check({tag, ".ctrl"},        32'(ctrl),        32'(c));
    check({tag, ".illegal"},     32'(illegal),     32'(ill));
    check({tag, ".count"},       32'(instr_count), 32'(cnt));
  endtask

  task automatic drive(input logic [15:0] ins, input logic [3:0] cvzn, input logic st);
    instr = ins;
    {Pre_C, Pre_V, Pre_Z, Pre_N} = cvzn;
    start = st;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_defined(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd24, 5'd25, 5'd26, 5'd28, 5'd31};
  endfunction

  // Expected RUN-cycle control word straight from the opcode table.
  function automatic logic [17:0] ref_ctrl(input logic [15:0] ins, input bit z, input bit c,
                                          input bit n, input bit v);
    logic [7:0]  cond_tab;
    logic [17:0] m;
    cond_tab = {1'b1, v, !n, n, !c, c, !z, z};
    m = '0;
    case (ins[15:11])
      5'd0: begin
        m = M_ALURF | M_RFW;
        if (ins[1:0] == 2'd1) m |= M_ADC;
        if (ins[1:0] == 2'd2) m |= M_SUB;
        if (ins[1:0] == 2'd3) m |= M_SBB;
      end
      5'd1:  m = M_LLI | M_RFW;
      5'd2:  m = M_LHI | M_RDB | M_RFW;
      5'd3:  m = M_ALUB | M_MEMRF | M_RFW;
      5'd5:  m = M_ALUB | M_RDB | M_DWE;
      5'd6:  m = M_RMRF | M_RFW;
      5'd24: m = cond_tab[ins[10:8]] ? (M_BR | M_LBL) : 18'd0;
      5'd25: m = M_JMP | M_RMPC;
      5'd26: m = M_JMP | M_RDPC;
      5'd28: m = M_OUT;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Behavioural model state for the random phase.
  bit m_run, m_halt, m_clear, m_ill;
  bit mz, mc, mn, mv;
  logic [CNT_W-1:0] m_cnt;

  logic [4:0]  r_op;
  logic [15:0] r_ins;
  logic [3:0]  r_fl;
  bit          r_st;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{16'h1900, 4'b0000, 1'b0, M_ALUB | M_MEMRF | M_RFW};
    vecs[1]  = '{16'h2900, 4'b0000, 1'b0, M_ALUB | M_RDB | M_DWE};
    vecs[2]  = '{16'h0002, 4'b0010, 1'b0, M_ALURF | M_RFW | M_SUB};
    vecs[3]  = '{16'hC000, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[4]  = '{16'h0002, 4'b0000, 1'b0, M_ALURF | M_RFW | M_SUB};
    vecs[5]  = '{16'hC000, 4'b0000, 1'b0, 18'd0};
    vecs[6]  = '{16'h0001, 4'b1000, 1'b0, M_ALURF | M_RFW | M_ADC};
    vecs[7]  = '{16'hC200, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[8]  = '{16'hC300, 4'b0000, 1'b0, 18'd0};
    vecs[9]  = '{16'h0003, 4'b0101, 1'b0, M_ALURF | M_RFW | M_SBB};
    vecs[10] = '{16'hC400, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[11] = '{16'hC600, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[12] = '{16'hC500, 4'b0000, 1'b0, 18'd0};
    vecs[13] = '{16'hC100, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[14] = '{16'hC700, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[15] = '{16'h0800, 4'b0000, 1'b0, M_LLI | M_RFW};
    vecs[16] = '{16'h1000, 4'b0000, 1'b0, M_LHI | M_RDB | M_RFW};
    vecs[17] = '{16'h3000, 4'b0000, 1'b0, M_RMRF | M_RFW};
    vecs[18] = '{16'hC800, 4'b0000, 1'b0, M_JMP | M_RMPC};
    vecs[19] = '{16'hD000, 4'b0000, 1'b0, M_JMP | M_RDPC};
    vecs[20] = '{16'hE000, 4'b0000, 1'b0, M_OUT};
    vecs[21] = '{16'h0000, 4'b1111, 1'b0, M_ALURF | M_RFW};
    vecs[22] = '{16'hC000, 4'b0000, 1'b0, M_BR | M_LBL};
    vecs[23] = '{16'hC000, 4'b0000, 1'b1, M_BR | M_LBL};
    vecs[24] = '{16'hE000, 4'b0000, 1'b0, M_OUT};

    // Reset state, with an LDR on the bus to show controls stay low.
    clr_n = 1'b0;
    drive(16'h1900, 4'b1111, 1'b0);
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, '0);
    tick();
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(16'h1900, 4'b0000, 1'b0);
      check_status("idle_wait", 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, '0);
      tick();
    end

    // Start pulse -> single CLEAR cycle -> RUN.
    drive(16'h1900, 4'b0000, 1'b1);
    check_status("idle_start", 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, '0);
    tick();
    drive(16'h1900, 4'b0000, 1'b0);
    check_status("clear", 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 1'b0, '0);
    tick();

    // Directed RUN vectors; count saturates at CNT_MAX partway through.
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].ins, vecs[i].cvzn, vecs[i].st);
      check_status($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, vecs[i].exp, 1'b0,
                   (i > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(i));
      tick();
    end

    // HLT: PC held, then HALT with saturated count preserved.
    drive(16'hF800, 4'b0000, 1'b0);
    check_status("hlt", 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, CNT_MAX);
    tick();
    drive(16'h1900, 4'b0000, 1'b0);
    check_status("halt0", 1'b1, 1'b0, 1'b0, 1'b1, 18'd0, 1'b0, CNT_MAX);
    tick();
    drive(16'h1900, 4'b0000, 1'b1);
    check_status("halt_start", 1'b1, 1'b0, 1'b0, 1'b1, 18'd0, 1'b0, CNT_MAX);
    tick();
    drive(16'h1900, 4'b0000, 1'b0);
    check_status("clear2", 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 1'b0, CNT_MAX);
    tick();

    // Three instructions then HLT -> count 3.
    drive(16'h0800, 4'b0000, 1'b0);
    check_status("cnt_a", 1'b0, 1'b0, 1'b1, 1'b0, M_LLI | M_RFW, 1'b0, 4'd0);
    tick();
    drive(16'h3000, 4'b0000, 1'b0);
    check_status("cnt_b", 1'b0, 1'b0, 1'b1, 1'b0, M_RMRF | M_RFW, 1'b0, 4'd1);
    tick();
    drive(16'hE000, 4'b0000, 1'b0);
    check_status("cnt_c", 1'b0, 1'b0, 1'b1, 1'b0, M_OUT, 1'b0, 4'd2);
    tick();
    drive(16'hF800, 4'b0000, 1'b0);
    check_status("cnt_hlt", 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, 4'd3);
    tick();
    drive(16'h0000, 4'b0000, 1'b1);
    check_status("cnt_halted", 1'b1, 1'b0, 1'b0, 1'b1, 18'd0, 1'b0, 4'd3);
    tick();
    drive(16'h0000, 4'b0000, 1'b0);
    tick();
    drive(16'hA800, 4'b0000, 1'b0);
    check_status("illegal_op", 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 1'b0, 4'd0);
    tick();
    drive(16'h1900, 4'b0000, 1'b0);
    check_status("illegal_set", 1'b0, 1'b0, 1'b1, 1'b0, M_ALUB | M_MEMRF | M_RFW, 1'b1, 4'd1);
    tick();
    drive(16'hF800, 4'b0000, 1'b0);
    check_status("illegal_hlt", 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 1'b1, 4'd2);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(16'h0000, 4'b1111, 1'b0);
      check_status("illegal_halt", 1'b1, 1'b0, 1'b0, 1'b1, 18'd0, 1'b1, 4'd2);
      tick();
    end
    drive(16'h0000, 4'b0000, 1'b1);
    tick();
    drive(16'h0000, 4'b0000, 1'b0);
    check_status("illegal_clear", 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 1'b1, 4'd2);
    tick();
    drive(16'hA800, 4'b0000, 1'b0);
    check_status("illegal_cleared", 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 1'b0, 4'd0);
    tick();

    // Async reset between edges while an LDR is writing.
    drive(16'h1900, 4'b0000, 1'b0);
    check_status("pre_reset", 1'b0, 1'b0, 1'b1, 1'b0, M_ALUB | M_MEMRF | M_RFW, 1'b1, 4'd1);
    #1;
    clr_n = 1'b0;
    #1;
    check_status("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, 4'd0);
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(16'h1900, 4'b0000, 1'b0);
      check_status("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, 4'd0);
      tick();
    end

    // Randomized phase against the behavioural model, starting from IDLE.
    m_run = 0; m_halt = 0; m_clear = 0; m_ill = 0;
    mz = 0; mc = 0; mn = 0; mv = 0;
    m_cnt = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 4) r_op = 5'd31;
      else if ($urandom_range(0, 99) < 8) r_op = 5'($urandom_range(0, 31));
      else r_op = valid_ops[$urandom_range(0, 9)];
      r_ins = {r_op, 11'($urandom)};
      r_fl  = 4'($urandom);
      r_st  = (m_run || m_clear) ? 1'($urandom) : ($urandom_range(0, 3) == 0);
      drive(r_ins, r_fl, r_st);
      check_status($sformatf("rnd%0d", i), !(m_run || m_clear), m_clear,
                   m_run && (r_op != 5'd31), m_halt,
                   m_run ? ref_ctrl(r_ins, mz, mc, mn, mv) : 18'd0, m_ill, m_cnt);
      tick();
      if (m_clear) begin
        m_clear = 0; m_run = 1;
        mz = 0; mc = 0; mn = 0; mv = 0;
        m_cnt = '0; m_ill = 0;
      end else if (m_run) begin
        if (r_op == 5'd31) begin
          m_run = 0; m_halt = 1;
        end else begin
          if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
          if (r_op == 5'd0) {mc, mv, mz, mn} = r_fl;
          if (!is_defined(r_op)) m_ill = 1;
        end
      end else if (r_st) begin
        m_halt = 0; m_clear = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
